// File: rtl/regfile_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_pkg
// Shared definitions for the register-file write arbiter:
//   - default widths / entry count
//   - FSM state encoding (ST_CLEAR, ST_RUN)
//   - requester source IDs used by the round-robin arbiter (SRC_ALU, SRC_MEM)
// ---------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_NUM_REGS = 32;

  // Controller state: CLEAR walks every entry writing zero, RUN serves requesters
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arbState_e;

  // Source IDs double as bit positions in the arbiter request/grant vectors
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // One-hot grant vector to the source ID it selects (MEM when bit 1 is set)
  function automatic logic grantToSrc(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant, purely combinational.
// Ports:
//   req  in  [1:0]  request vector (bit 0 = ALU, bit 1 = MEM)
//   last in  1      source that won the most recent grant
//   en   in  1      grant enable; when low no grant is issued
//   gnt  out [1:0]  one-hot grant, or zero
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  // On contention the source that did not win last time gets the port
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Owns the single write port of the register file and shares it between the
// ALU and MEM writeback requesters (valid/ready, round-robin). After reset or
// on clear_req it zeroes every entry, one per cycle.
// Ports:
//   CLK, MasterReset            clock, synchronous active-high reset
//   alu_valid/addr/data, alu_ready   ALU writeback handshake
//   mem_valid/addr/data, mem_ready   MEM writeback handshake
//   clear_req                   level request for a full clear
//   clear_busy                  high while the clear sequence runs
//   RegWrite/writeReg/writeData registered register-file write port
// ---------------------------------------------------------------------------
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
  input  logic              CLK,
  input  logic              MasterReset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  arbState_e         state;
  arbState_e         nextState;
  logic [ADDR_W-1:0] clrPtr;
  logic [ADDR_W-1:0] nextClrPtr;
  logic              rrLast;
  logic              nextRrLast;
  logic              nextRegWrite;
  logic [ADDR_W-1:0] nextWriteReg;
  logic [DATA_W-1:0] nextWriteData;
  logic              arbEn;
  logic [1:0]        gnt;
  logic              winSrc;

  // Grants only in RUN, and a pending clear blocks every grant
  assign arbEn = (state == ST_RUN) && !clear_req;

  rr_arbiter2 uArb (
    .req  ({mem_valid, alu_valid}),
    .last (rrLast),
    .en   (arbEn),
    .gnt  (gnt)
  );

  assign alu_ready = gnt[SRC_ALU];
  assign mem_ready = gnt[SRC_MEM];
  assign winSrc    = grantToSrc(gnt);

  // Next-state and next write-port values
  always_comb begin
    nextState     = state;
    nextClrPtr    = clrPtr;
    nextRrLast    = rrLast;
    nextRegWrite  = 1'b0;
    nextWriteReg  = writeReg;
    nextWriteData = writeData;

    case (state)
      ST_CLEAR: begin
        nextRegWrite  = 1'b1;
        nextWriteReg  = clrPtr;
        nextWriteData = '0;
        nextClrPtr    = clrPtr + ADDR_W'(1);
        if (clrPtr == LAST_PTR) begin
          nextState  = ST_RUN;
          nextClrPtr = '0;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          nextState  = ST_CLEAR;
          nextClrPtr = '0;
        end else if (gnt != 2'b00) begin
          nextWriteReg  = (winSrc == SRC_MEM) ? mem_addr : alu_addr;
          nextWriteData = (winSrc == SRC_MEM) ? mem_data : alu_data;
          // r0 is hardwired zero: consume the request but suppress the write
          nextRegWrite  = (nextWriteReg != '0);
          nextRrLast    = winSrc;
        end
      end
      default: begin
        nextState  = ST_CLEAR;
        nextClrPtr = '0;
      end
    endcase
  end

  // State, pointers and registered write port
  always_ff @(posedge CLK) begin
    if (MasterReset) begin
      state      <= ST_CLEAR;
      clrPtr     <= '0;
      rrLast     <= SRC_MEM;
      RegWrite   <= 1'b0;
      writeReg   <= '0;
      writeData  <= '0;
      clear_busy <= 1'b1;
    end else begin
      state      <= nextState;
      clrPtr     <= nextClrPtr;
      rrLast     <= nextRrLast;
      RegWrite   <= nextRegWrite;
      writeReg   <= nextWriteReg;
      writeData  <= nextWriteData;
      clear_busy <= (nextState == ST_CLEAR);
    end
  end

endmodule
